// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path:
//   - uart_tx_state_t : transmitter FSM states
//   - PAR_EVEN/PAR_ODD: parity-mode encodings for the PARITY_ODD parameter
//   - BAUD_DIV_9600_50M: clock cycles per bit for 9600 baud from a 50 MHz clock
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    localparam int BAUD_DIV_9600_50M = 5208;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with first-word-fall-through output: dout always shows
// the head entry while empty is low, and pop simply advances past it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write strobe and data; ignored while full unless pop is also high
//   pop        : read strobe; ignored while empty
//   dout       : head entry
//   full, empty: occupancy flags
//   level      : number of entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit, so their difference is the exact
    // occupancy including the completely-full case.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push while full is accepted only when a pop frees the head slot in
    // the same cycle; the head is read before the write lands.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, so clearing the array would add logic for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter fed by an internal FIFO. Bytes written with wr_en are
// queued and sent back-to-back as: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Each bit lasts BAUD_DIV clocks.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din, wr_en : byte to queue and its single-cycle write strobe
//   full, level: FIFO full flag and occupancy
//   overflow   : sticky, set by a write that was dropped because the FIFO was full
//   tx         : registered serial output, idles high
//   busy       : frame in progress
//   done       : one-cycle pulse during the last cycle of each frame's final stop bit
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = PAR_EVEN,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_DIV   = BAUD_DIV_9600_50M,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          done
);

    localparam int CW  = $clog2(BAUD_DIV);
    localparam int BCW = $clog2(DATA_BITS);

    uart_tx_state_t       state;
    logic [CW-1:0]        baud_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bit_end   = (baud_cnt == '0);
    assign last_data = (bit_cnt == BCW'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BCW'(STOP_BITS - 1));

    // Fetch the next byte when idle, or at the very end of the final stop
    // bit so the next start bit follows with no gap.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || (state == STOP && bit_end && last_stop));

    // tx, busy and done are registered from the state held in the current
    // cycle, so the line trails the FSM by one clock but never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side below sees the pre-edge state regardless of statement order.
            busy <= (state != IDLE);
            done <= 1'b0;

            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shreg[0];
                PARITY:  tx <= par_bit;
                default: tx <= 1'b1;
            endcase

            case (state)
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        baud_cnt <= CW'(BAUD_DIV - 1);
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg    <= shreg >> 1;
                        baud_cnt <= CW'(BAUD_DIV - 1);
                        if (last_data) begin
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        bit_cnt  <= '0;
                        baud_cnt <= CW'(BAUD_DIV - 1);
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            baud_cnt <= CW'(BAUD_DIV - 1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: ;
            endcase

            // A pop overrides the per-state update: load the next frame and
            // start its start bit, from IDLE or straight out of STOP.
            if (pop) begin
                state    <= START;
                shreg    <= fifo_dout;
                par_bit  <= (^fifo_dout) ^ (PARITY_ODD == PAR_ODD);
                bit_cnt  <= '0;
                baud_cnt <= CW'(BAUD_DIV - 1);
            end
        end
    end

    // Only a write that is actually dropped counts; a write that coincides
    // with a pop while full is accepted by the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo. Instance a: 8N1, BAUD_DIV=4, FIFO_DEPTH=4.
// Instance b: 8 data bits, odd parity, 2 stop bits, BAUD_DIV=4, FIFO_DEPTH=16.
// A small receiver on instance a decodes frames so multi-frame tests can
// compare the delivered byte sequence.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;

    logic [7:0] din_a;
    logic       wr_en_a;
    logic       full_a;
    logic [2:0] level_a;
    logic       ovf_a;
    logic       tx_a;
    logic       busy_a;
    logic       done_a;

    logic [7:0] din_b;
    logic       wr_en_b;
    logic       full_b;
    logic [4:0] level_b;
    logic       ovf_b;
    logic       tx_b;
    logic       busy_b;
    logic       done_b;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .DATA_BITS (8), .PARITY_EN (0), .PARITY_ODD (0),
        .STOP_BITS (1), .BAUD_DIV (4), .FIFO_DEPTH (4)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .din (din_a), .wr_en (wr_en_a),
        .full (full_a), .level (level_a), .overflow (ovf_a),
        .tx (tx_a), .busy (busy_a), .done (done_a)
    );

    uart_tx_fifo #(
        .DATA_BITS (8), .PARITY_EN (1), .PARITY_ODD (1),
        .STOP_BITS (2), .BAUD_DIV (4), .FIFO_DEPTH (16)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .din (din_b), .wr_en (wr_en_b),
        .full (full_b), .level (level_b), .overflow (ovf_b),
        .tx (tx_b), .busy (busy_b), .done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver for instance a (8N1, 4 clocks per bit). Start is seen in the
    // first start-bit cycle; each later bit is sampled in its third cycle.
    logic [63:0] rx_word;
    int          rx_n;
    int          rx_frame_err;
    int          done_cnt_a;
    bit          rx_active;
    int          rx_cnt;
    int          rx_idx;
    logic [7:0]  rx_shift;

    initial begin
        rx_word = '0; rx_n = 0; rx_frame_err = 0; done_cnt_a = 0;
        rx_active = 1'b0; rx_cnt = 0; rx_shift = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (done_a === 1'b1) done_cnt_a++;
            if (!rx_active) begin
                if (tx_a === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % 4 == 2) begin
                    rx_idx = rx_cnt / 4 - 1;
                    if (rx_idx < 8) begin
                        rx_shift[rx_idx] = tx_a;
                    end else begin
                        if (tx_a !== 1'b1) rx_frame_err++;
                        rx_word   = {rx_word[55:0], rx_shift};
                        rx_n++;
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic clear_rx();
        rx_word = '0; rx_n = 0; rx_frame_err = 0; done_cnt_a = 0;
    endtask

    // Waits for instance a to become busy and then drain completely.
    task automatic wait_frames_a(input string name, input int budget);
        int n;
        n = 0;
        while (busy_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        while (busy_a !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain timeout after %0d cycles, busy=%b", name, n, busy_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din_a = '0; wr_en_a = 1'b0; din_b = '0; wr_en_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL reset_tx got %b exp 1", tx_a); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
        checks++; if (full_a !== 1'b0)  begin errors++; $display("FAIL reset_full got %b exp 0", full_a); end
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_a); end
        checks++; if (ovf_a !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf_a); end
        checks++; if (tx_b !== 1'b1)    begin errors++; $display("FAIL reset_tx_b got %b exp 1", tx_b); end
        checks++; if (level_b !== 5'd0) begin errors++; $display("FAIL reset_level_b got %0d exp 0", level_b); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got tx=%b busy=%b exp tx=1 busy=0", tx_a, busy_a);
        end
    endtask

    // 0xA5 on 8N1: tx falls two clocks after the write edge, 40-clock frame.
    task automatic test_single_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        clear_rx();
        @(negedge clk); din_a = 8'hA5; wr_en_a = 1'b1;
        @(negedge clk); wr_en_a = 1'b0;
        checks++; if (level_a !== 3'd1) begin errors++; $display("FAIL single_level_pushed got %0d exp 1", level_a); end
        checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL single_tx_n1 got %b exp 1", tx_a); end
        @(negedge clk);
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL single_level_popped got %0d exp 0", level_a); end
        checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL single_tx_n2 got %b exp 1", tx_a); end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (tx_a !== frame[(c-1)/4]) begin
                errors++; $display("FAIL single_tx_cycle%0d got %b exp %b", c, tx_a, frame[(c-1)/4]);
            end
            checks++;
            if (done_a !== (c == 40)) begin
                errors++; $display("FAIL single_done_cycle%0d got %b exp %b", c, done_a, (c == 40));
            end
        end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL single_done_end got %b exp 0", done_a); end
        checks++; if (done_cnt_a !== 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", done_cnt_a); end
        checks++; if (rx_n !== 1 || rx_word[7:0] !== 8'hA5) begin
            errors++; $display("FAIL single_rx got n=%0d byte=%h exp n=1 byte=a5", rx_n, rx_word[7:0]);
        end
    endtask

    // 0x03 with odd parity and two stop bits: parity bit 1, 48-clock frame.
    task automatic test_parity();
        logic [11:0] frame;
        int          dones;
        frame = {2'b11, 1'b1, 8'h03, 1'b0};
        dones = 0;
        @(negedge clk); din_b = 8'h03; wr_en_b = 1'b1;
        @(negedge clk); wr_en_b = 1'b0;
        checks++; if (level_b !== 5'd1) begin errors++; $display("FAIL parity_level_pushed got %0d exp 1", level_b); end
        @(negedge clk);
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (done_b === 1'b1) dones++;
            checks++;
            if (tx_b !== frame[(c-1)/4]) begin
                errors++; $display("FAIL parity_tx_cycle%0d got %b exp %b", c, tx_b, frame[(c-1)/4]);
            end
            if (c == 48) begin
                checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL parity_done_last got %b exp 1", done_b); end
            end
        end
        @(negedge clk);
        checks++; if (dones !== 1)     begin errors++; $display("FAIL parity_done_count got %0d exp 1", dones); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL parity_busy_end got %b exp 0", busy_b); end
        checks++; if (tx_b !== 1'b1)   begin errors++; $display("FAIL parity_tx_end got %b exp 1", tx_b); end
    endtask

    // Three writes on consecutive clocks: 120 busy clocks, done at 40/80/120.
    task automatic test_back_to_back();
        int c;
        int done_at[$];
        clear_rx();
        @(negedge clk); din_a = 8'h11; wr_en_a = 1'b1;
        @(negedge clk); din_a = 8'h22;
        @(negedge clk); din_a = 8'h33;
        @(negedge clk); wr_en_a = 1'b0;
        c = 0;
        while (busy_a === 1'b1 && c < 200) begin
            c++;
            if (done_a === 1'b1) done_at.push_back(c);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++; if (c !== 120) begin errors++; $display("FAIL b2b_busy_length got %0d exp 120", c); end
        checks++;
        if (done_at.size() !== 3) begin
            errors++; $display("FAIL b2b_done_count got %0d exp 3", done_at.size());
        end else if (done_at[0] !== 40 || done_at[1] !== 80 || done_at[2] !== 120) begin
            errors++; $display("FAIL b2b_done_cycles got %0d,%0d,%0d exp 40,80,120", done_at[0], done_at[1], done_at[2]);
        end
        checks++; if (rx_n !== 3 || rx_word[23:0] !== 24'h112233) begin
            errors++; $display("FAIL b2b_rx got n=%0d data=%h exp n=3 data=112233", rx_n, rx_word[23:0]);
        end
        checks++; if (rx_frame_err !== 0) begin errors++; $display("FAIL b2b_stop_bits got %0d bad exp 0", rx_frame_err); end
    endtask

    // Depth 4: one byte shifting, five more written; the fifth is dropped.
    task automatic test_overflow();
        clear_rx();
        @(negedge clk); din_a = 8'h40; wr_en_a = 1'b1;
        @(negedge clk); wr_en_a = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (level_a !== 3'(k)) begin errors++; $display("FAIL ovf_level_k%0d got %0d exp %0d", k, level_a, k); end
            checks++; if (full_a !== (k == 4)) begin errors++; $display("FAIL ovf_full_k%0d got %b exp %b", k, full_a, (k == 4)); end
            checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_early_k%0d got %b exp 0", k, ovf_a); end
            din_a = 8'(8'h41 + k); wr_en_a = 1'b1;
        end
        @(negedge clk); wr_en_a = 1'b0;
        checks++; if (level_a !== 3'd4) begin errors++; $display("FAIL ovf_level_hold got %0d exp 4", level_a); end
        checks++; if (full_a !== 1'b1)  begin errors++; $display("FAIL ovf_full_hold got %b exp 1", full_a); end
        checks++; if (ovf_a !== 1'b1)   begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_a); end
        wait_frames_a("ovf", 400);
        checks++; if (rx_n !== 5 || rx_word[39:0] !== 40'h4041424344) begin
            errors++; $display("FAIL ovf_rx got n=%0d data=%h exp n=5 data=4041424344", rx_n, rx_word[39:0]);
        end
        checks++; if (done_cnt_a !== 5) begin errors++; $display("FAIL ovf_done_count got %0d exp 5", done_cnt_a); end
        checks++; if (ovf_a !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_a); end
    endtask

    // Full FIFO, write lands on the edge where STOP pops the next byte.
    task automatic test_full_push_pop();
        @(negedge clk); rst_n = 1'b0; wr_en_a = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL fpp_overflow_cleared got %b exp 0", ovf_a); end
        clear_rx();
        for (int t = 0; t <= 42; t++) begin
            @(negedge clk);
            if (t == 41) begin
                checks++; if (level_a !== 3'd4 || full_a !== 1'b1) begin
                    errors++; $display("FAIL fpp_full_before got level=%0d full=%b exp 4/1", level_a, full_a);
                end
            end
            if (t == 42) begin
                checks++; if (level_a !== 3'd4) begin errors++; $display("FAIL fpp_level got %0d exp 4", level_a); end
                checks++; if (full_a !== 1'b1)  begin errors++; $display("FAIL fpp_full got %b exp 1", full_a); end
                checks++; if (ovf_a !== 1'b0)   begin errors++; $display("FAIL fpp_overflow got %b exp 0", ovf_a); end
                checks++; if (done_a !== 1'b1)  begin errors++; $display("FAIL fpp_done_at_pop got %b exp 1", done_a); end
            end
            wr_en_a = (t == 0) || (t >= 3 && t <= 6) || (t == 41);
            din_a   = (t == 0) ? 8'h50 : (t == 41) ? 8'h55 : 8'(8'h51 + (t - 3));
        end
        wr_en_a = 1'b0;
        wait_frames_a("fpp", 400);
        checks++; if (rx_n !== 6 || rx_word[47:0] !== 48'h505152535455) begin
            errors++; $display("FAIL fpp_rx got n=%0d data=%h exp n=6 data=505152535455", rx_n, rx_word[47:0]);
        end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL fpp_overflow_end got %b exp 0", ovf_a); end
    endtask

    // Reset during data bit 0 of 0x60 with three bytes queued behind it.
    task automatic test_reset_mid();
        int bad;
        clear_rx();
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            wr_en_a = (t <= 3);
            din_a   = 8'(8'h60 + t);
        end
        checks++; if (level_a !== 3'd3) begin errors++; $display("FAIL rmid_level_before got %0d exp 3", level_a); end
        checks++; if (tx_a !== 1'b0)    begin errors++; $display("FAIL rmid_tx_before got %b exp 0", tx_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL rmid_tx_async got %b exp 1", tx_a); end
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL rmid_level got %0d exp 0", level_a); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL rmid_busy got %b exp 0", busy_a); end
        @(negedge clk);
        clear_rx();
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles exp 0", bad); end
        checks++; if (rx_n !== 0) begin errors++; $display("FAIL rmid_no_frame got %0d frames exp 0", rx_n); end
        @(negedge clk); din_a = 8'h7E; wr_en_a = 1'b1;
        @(negedge clk); wr_en_a = 1'b0;
        wait_frames_a("rmid", 100);
        checks++; if (rx_n !== 1 || rx_word[7:0] !== 8'h7E) begin
            errors++; $display("FAIL rmid_new_frame got n=%0d byte=%h exp n=1 byte=7e", rx_n, rx_word[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, used to drive the Bluetooth module's RX pin. It replaces the fixed 11-bit, enable/RW-driven transmitter. Frame format, baud divisor and buffer depth are set by parameters. Bytes are queued with a single-cycle write strobe and serialised back-to-back, LSB first.

## Interface
- `DATA_BITS`, 8: payload bits per frame, from 5 to 9.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `BAUD_DIV`, 5208: clock cycles per bit (50 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, 16: transmit buffer entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  DATA_BITS  byte to queue.
- `wr_en`  in  1  write strobe; `din` is pushed if not `full`.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a write was attempted while full.
- `tx`  out  1  serial line, idles high.
- `busy`  out  1  a frame is being shifted.
- `done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `full`=0, `level`=0, `overflow`=0. The FIFO is emptied, the FSM goes to IDLE and the baud counter is cleared.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronously). The partial frame and all queued data are discarded.
- Frame layout: start bit (0), then `DATA_BITS` data bits LSB first, then an optional parity bit, then `STOP_BITS` stop bits (1).
- Parity is the XOR of the data bits, inverted when `PARITY_ODD`=1.
- FSM states and transitions:
  - IDLE → START when the FIFO is not empty. This pops the head entry into the shift register and loads the baud counter.
  - START → DATA.
  - DATA: stays here for `DATA_BITS` bits, then moves to PARITY if `PARITY_EN`, otherwise to STOP.
  - PARITY → STOP.
  - STOP: after `STOP_BITS` bits, goes to START if the FIFO is non-empty (popping in the same cycle), otherwise to IDLE.
- Every bit is held for exactly `BAUD_DIV` clocks. The down-counter reloads with `BAUD_DIV`-1 and the FSM advances when the counter reads 0.
- `busy` is high in every state except IDLE.
- `done` pulses in the final cycle of the last stop bit, on every frame.
- Write while full: the data is dropped, `level` is unchanged, and `overflow` sets and stays set until reset.
- Simultaneous push and pop while full: both take effect, `level` is unchanged, and `overflow` does not set.
- Simultaneous push and pop while empty: impossible by construction, because a pop requires `level` > 0 in that cycle.
- `level` counts up to and including `FIFO_DEPTH`. Read and write pointers are one bit wider than the address and wrap naturally.

## Timing
- Latency when idle and empty: `wr_en` sampled at edge N; entry visible at N+1; pop at N+1; `tx` falls at N+2.
- Frame length: (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `BAUD_DIV` clocks. With defaults this is 10 × 5208 = 52 080 clocks.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit cycle, with zero idle gap.
- `busy` stays high across back-to-back frames, and `done` pulses once per frame.
- `full` and `level` update on the clock edge after the push or pop. A write accepted in the same cycle that `full` rises is allowed.
- `tx` is driven from a register, so the line is glitch-free.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants;
  - the `BAUD_DIV` default for 9600 baud at 50 MHz.
- Sub-module `sync_fifo`, with parameters WIDTH and DEPTH and ports push/pop/din/dout/full/empty/level. It has first-word-fall-through output. The top level contains the FSM, baud counter and shift register.

## Test plan
- Defaults, `BAUD_DIV`=4, write 0xA5 once → `tx` falls 2 clocks later. Then bits 1,0,1,0,0,1,0,1, each 4 clocks, then a stop bit. `done` pulses once at clock 40 of the frame, then `busy`=0.
- `PARITY_EN`=1, `PARITY_ODD`=1, `STOP_BITS`=2, byte 0x03 → parity bit 1, two stop bits, frame length 12×`BAUD_DIV`.
- Burst-write 3 bytes on consecutive clocks → three frames with no idle gap, three `done` pulses, and `busy` held high throughout.
- `FIFO_DEPTH`=4: write 6 bytes while the first frame is shifting → `full`=1 at `level`=4, `overflow`=1, and the last byte is dropped. Five frames are transmitted: one shifting plus four queued.
- When full, issue `wr_en` in the same cycle as the FSM pop → the byte is accepted, `level` stays at 4, and `overflow` stays 0.
- Assert `rst_n`=0 mid-data-bit with 3 bytes queued → `tx`=1 immediately, `level`=0, `busy`=0. After release, no frame is sent until a new write.
